// File: rtl/wb_uart_slave.sv
`default_nettype none
// ============================================================================
// wb_uart_slave : Wishbone-classic 8N1 UART with TX/RX FIFOs and baud divisor
// Revision      : 1.0
// ============================================================================
module wb_uart_slave #(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        req, tx_wr_req, tx_stall, do_ack, tx_push, tx_pop;
    logic        rx_pop, rx_push, rx_push_req, flag_clr, div_wr;
    logic        tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic        rx_overrun, frame_err, overrun_set, frame_set;
    logic [1:0]  reg_sel;
    logic [15:0] div, div_merge, div_next;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[15:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    // ---------------- bus decode ----------------
    assign reg_sel   = wb_adr_i[3:2];
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign tx_wr_req = req & wb_we_i & (reg_sel == 2'd0) & wb_sel_i[0];
    // A full TX FIFO only stalls the master if the shifter is not popping this cycle.
    assign tx_stall  = tx_wr_req & tx_full & ~tx_pop;
    assign do_ack    = req & ~tx_stall;
    assign tx_push   = tx_wr_req & ~tx_stall;
    assign rx_pop    = do_ack & wb_we_i & (reg_sel == 2'd1) & ~rx_empty;
    assign flag_clr  = do_ack & wb_we_i & (reg_sel == 2'd2) & wb_sel_i[0];
    assign div_wr    = do_ack & wb_we_i & (reg_sel == 2'd3);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wb_ack_o <= 1'b0;
        else          wb_ack_o <= do_ack;
    end

    always_comb begin
        div_merge = div;
        if (wb_sel_i[0]) div_merge[7:0]  = wb_dat_i[7:0];
        if (wb_sel_i[1]) div_merge[15:8] = wb_dat_i[15:8];
        div_next = (div_merge < 16'd4) ? 16'd4 : div_merge;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)    div <= DIV_RESET;
        else if (div_wr) div <= div_next;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [TX_DEPTH];
    logic [TXAW:0] tx_wptr, tx_rptr;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TXAW] != tx_rptr[TXAW]) &&
                      (tx_wptr[TXAW-1:0] == tx_rptr[TXAW-1:0]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr[TXAW-1:0]] <= wb_dat_i[7:0];
    end

    // ---------------- TX shifter ----------------
    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick;

    assign tx_tick = (tx_cnt == 16'd0);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) begin
                          tx_state_nxt = TX_START;
                          tx_pop       = 1'b1;
                      end
            TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
            TX_STOP:  if (tx_tick) begin
                          if (!tx_empty) begin
                              tx_state_nxt = TX_START;
                              tx_pop       = 1'b1;
                          end else begin
                              tx_state_nxt = TX_IDLE;
                          end
                      end
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_RESET;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_pop) begin
                // Divisor is sampled per frame so mid-frame DIV writes do not distort bits.
                tx_shift <= tx_mem[tx_rptr[TXAW-1:0]];
                tx_div   <= div;
                tx_cnt   <= div - 16'd1;
                tx_bit   <= '0;
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= tx_div - 16'd1;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    assign uart_tx_o = (tx_state == TX_START) ? 1'b0 :
                       (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
    assign tx_busy   = ~tx_empty | (tx_state != TX_IDLE);

    // ---------------- RX deserialiser ----------------
    rx_state_t   rx_state, rx_state_nxt;
    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_tick, rx_stop_tick;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_cnt == 16'd0);

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_state_nxt = RX_START;
            RX_START: if (rx_tick) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_stop_tick = (rx_state == RX_STOP) & rx_tick;
    assign rx_push_req  = rx_stop_tick & rx_s;
    assign frame_set    = rx_stop_tick & ~rx_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_RESET;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], uart_rx_i};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
            if (rx_state == RX_IDLE) begin
                if (rx_state_nxt == RX_START) begin
                    rx_div <= div;
                    rx_cnt <= {1'b0, div[15:1]} - 16'd1;
                end
            end else if (rx_tick) begin
                rx_cnt <= rx_div - 16'd1;
                if (rx_state == RX_START) rx_bit <= '0;
                if (rx_state == RX_DATA) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [RX_DEPTH];
    logic [RXAW:0] rx_wptr, rx_rptr;

    assign rx_empty    = (rx_wptr == rx_rptr);
    assign rx_full     = (rx_wptr[RXAW] != rx_rptr[RXAW]) &&
                         (rx_wptr[RXAW-1:0] == rx_rptr[RXAW-1:0]);
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign overrun_set = rx_push_req & rx_full & ~rx_pop;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr[RXAW-1:0]] <= rx_shift;
    end

    // Set is applied after clear so a coincident event is never lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (flag_clr && wb_dat_i[5]) rx_overrun <= 1'b0;
            if (flag_clr && wb_dat_i[6]) frame_err  <= 1'b0;
            if (overrun_set)             rx_overrun <= 1'b1;
            if (frame_set)               frame_err  <= 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        wb_dat_o = 32'd0;
        case (reg_sel)
            2'd1:    if (!rx_empty) wb_dat_o = {24'd0, rx_mem[rx_rptr[RXAW-1:0]]};
            2'd2:    wb_dat_o = {25'd0, frame_err, rx_overrun, tx_busy,
                                 rx_full, ~rx_empty, tx_empty, tx_full};
            2'd3:    wb_dat_o = {16'd0, div};
            default: wb_dat_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_uart_slave.sv
`default_nettype none
// ============================================================================
// tb_wb_uart_slave : scoreboard bench for wb_uart_slave (reads and TX serial)
// Revision         : 1.0
// ============================================================================
module tb_wb_uart_slave;
    localparam int DIV = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [15:0] adr = 16'h0;
    logic [31:0] dat = 32'h0;
    logic        ack, tx;
    logic [31:0] rdat;
    logic        rx = 1'b1;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t       rd_q[$];
    logic [7:0] tx_q[$];
    int         n_cmp = 0, n_err = 0;
    int         cycle = 0;
    bit         mon_off = 1'b0, btb = 1'b0;
    int         btb_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    wb_uart_slave #(.TX_DEPTH(16), .RX_DEPTH(16), .DIV_RESET(16'd868)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_ack_o(ack), .wb_dat_o(rdat),
        .uart_rx_i(rx), .uart_tx_o(tx)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    task automatic bus(input logic w, input logic [1:0] r, input logic [3:0] s,
                       input logic [31:0] d, output int waits);
        @(negedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = {12'h0, r, 2'b00}; dat = d;
        waits = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (!ack && waits < 4000);
        if (!ack) fail("bus_timeout");
        @(negedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] r, input logic [3:0] s, input logic [31:0] d);
        int w;
        bus(1'b1, r, s, d, w);
    endtask

    task automatic rd(input logic [1:0] r, input logic [31:0] e, input string nm);
        exp_t x;
        int   w;
        x.nm = nm;
        x.v  = e;
        rd_q.push_back(x);
        bus(1'b0, r, 4'hF, 32'h0, w);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_drain(input int limit);
        int n = 0;
        while (tx_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (tx_q.size() != 0) fail("tx_drain_timeout");
    endtask

    // Read monitor: compares read data during the acknowledged cycle.
    always @(negedge clk) begin
        if (ack && !we) begin
            if (rd_q.size() == 0) fail("rd_unexpected");
            else begin
                exp_t x;
                x = rd_q.pop_front();
                check(x.nm, rdat, x.v);
            end
        end
    end

    // TX monitor: decodes serial frames mid-bit and checks them against tx_q.
    initial begin : tx_mon
        logic [7:0] b;
        logic       st, sb;
        int         t_start, t_prev;
        t_prev = 0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                t_start = cycle;
                repeat (DIV / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                sb = tx;
                if (!mon_off) begin
                    check("tx_start_bit", {31'd0, st}, 32'd0);
                    check("tx_stop_bit", {31'd0, sb}, 32'd1);
                    if (tx_q.size() == 0) fail("tx_unexpected_frame");
                    else check("tx_byte", {24'd0, b}, {24'd0, tx_q.pop_front()});
                    if (btb) begin
                        if (btb_cnt > 0) check("tx_gap", t_start - t_prev, 10 * DIV);
                        btb_cnt++;
                    end
                end
                t_prev = t_start;
            end
        end
    end

    initial begin : stim
        int w;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(2'd2, 32'h2, "status_rst");
        rd(2'd3, 32'h364, "div_rst");
        check("idle_tx", {31'd0, tx}, 32'd1);

        // divisor clamp then set to 8
        wr(2'd3, 4'b0011, 32'h0002);
        rd(2'd3, 32'h4, "div_clamp");
        wr(2'd3, 4'b0011, DIV);
        rd(2'd3, DIV, "div8");

        // single byte
        tx_q.push_back(8'hA5);
        bus(1'b1, 2'd0, 4'h1, 32'hA5, w);
        check("tx_ack_latency", w, 1);
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, ack}, 32'd0);
        wait_tx_drain(200);
        repeat (10) @(negedge clk);
        rd(2'd2, 32'h2, "status_tx_done");

        // burst of 18: the 18th must stall until the second frame's start bit
        btb = 1'b1;
        btb_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            tx_q.push_back(8'h30 + 8'(i));
            bus(1'b1, 2'd0, 4'h1, 32'h30 + i, w);
            if (i < 17) check("burst_ack_latency", w, 1);
            else        check("full_write_stalled", {31'd0, w > 10}, 32'd1);
        end
        wait_tx_drain(18 * 10 * DIV + 200);
        btb = 1'b0;
        repeat (10) @(negedge clk);
        rd(2'd2, 32'h2, "status_burst_done");

        // single RX byte
        rx_frame(8'h3C, 1'b1);
        rd(2'd2, 32'h6, "status_rx_valid");
        rd(2'd1, 32'h3C, "rxdata_3c");
        wr(2'd1, 4'hF, 32'h0);
        rd(2'd2, 32'h2, "status_rx_popped");
        rd(2'd1, 32'h0, "rxdata_empty");

        // overrun
        for (int i = 0; i < 17; i++) rx_frame(8'h50 + 8'(i), 1'b1);
        rd(2'd2, 32'h2E, "status_overrun");
        wr(2'd2, 4'h1, 32'h20);
        rd(2'd2, 32'h0E, "status_ovr_clr");
        for (int i = 0; i < 16; i++) begin
            rd(2'd1, 32'h50 + i, "rx_fifo_entry");
            wr(2'd1, 4'hF, 32'h0);
        end
        rd(2'd2, 32'h2, "status_rx_drained");

        // framing error
        rx_frame(8'hA7, 1'b0);
        rd(2'd2, 32'h42, "status_frame_err");
        wr(2'd2, 4'h1, 32'h40);
        rd(2'd2, 32'h2, "status_fe_clr");

        // reset in the middle of a transmitted frame
        mon_off = 1'b1;
        for (int i = 0; i < 3; i++) wr(2'd0, 4'h1, 32'h00);
        repeat (12) @(negedge clk);
        check("tx_low_before_rst", {31'd0, tx}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("tx_async_rst", {31'd0, tx}, 32'd1);
        check("ack_async_rst", {31'd0, ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(2'd2, 32'h2, "status_after_rst");
        rd(2'd3, 32'h364, "div_after_rst");
        repeat (100) @(negedge clk);

        if (rd_q.size() != 0) fail("rd_queue_not_empty");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        fail("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
